// File: rtl/pwm_capture.sv
// Multi-channel PWM input capture: measures high time and period of each input
// in prescaled ticks and exposes them through a small register-mapped bus.
module pwm_capture #(
  parameter int pCHANNELS       = 4,
  parameter int pPRESCALER_BITS = 16,
  parameter int pCOUNT_BITS     = 32
) (
  input  logic                                 iCLOCK,
  input  logic                                 iRESET,
  input  logic [$clog2(2*pCHANNELS+2)-1:0]     iADDRESS,
  input  logic                                 iWRITE,
  input  logic [31:0]                          iWRITE_DATA,
  input  logic                                 iREAD,
  output logic [31:0]                          oREAD_DATA,
  input  logic [pCHANNELS-1:0]                 iPWM,
  output logic                                 oIRQ
);

  localparam int cAddrBits = $clog2(2*pCHANNELS+2);
  localparam logic [cAddrBits-1:0]       cAddrPres = '0;
  localparam logic [cAddrBits-1:0]       cAddrStat = cAddrBits'(1);
  localparam logic [pCOUNT_BITS-1:0]     cCntMax   = '1;
  localparam logic [pCOUNT_BITS-1:0]     cCntOne   = pCOUNT_BITS'(1);
  localparam logic [pPRESCALER_BITS-1:0] cPresOne  = pPRESCALER_BITS'(1);

  function automatic logic [pCOUNT_BITS-1:0] satInc(input logic [pCOUNT_BITS-1:0] v,
                                                    input logic t);
    satInc = (t && (v != cCntMax)) ? v + cCntOne : v;
  endfunction

  logic [pPRESCALER_BITS-1:0] presMax, presCnt;
  logic                       tick;
  logic [pCHANNELS-1:0]       pwmSyncP0, pwmSyncP1, pwmPrevP2;
  logic [pCHANNELS-1:0]       rise, fall, validSet, timeoutSet, valid, timeout;
  logic [pCOUNT_BITS-1:0]     highArr [pCHANNELS];
  logic [pCOUNT_BITS-1:0]     perArr  [pCHANNELS];
  logic [31:0]                rdNext;
  logic                       statW1c;
  logic                       unusedWdata;

  assign unusedWdata = ^iWRITE_DATA;
  assign statW1c     = iWRITE && (iADDRESS == cAddrStat);

  // Timebase: tick is registered, so it follows the wrapping compare by one cycle
  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      presMax <= '0;
      presCnt <= '0;
      tick    <= 1'b0;
    end else begin
      if (iWRITE && (iADDRESS == cAddrPres))
        presMax <= iWRITE_DATA[pPRESCALER_BITS-1:0];
      if (presCnt >= presMax) begin
        presCnt <= '0;
        tick    <= 1'b1;
      end else begin
        presCnt <= presCnt + cPresOne;
        tick    <= 1'b0;
      end
    end
  end

  // Stage p0/p1: synchronizer, p2: previous value for edge detection
  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      pwmSyncP0 <= '0;
      pwmSyncP1 <= '0;
      pwmPrevP2 <= '0;
    end else begin
      pwmSyncP0 <= iPWM;
      pwmSyncP1 <= pwmSyncP0;
      pwmPrevP2 <= pwmSyncP1;
    end
  end

  assign rise = pwmSyncP1 & ~pwmPrevP2;
  assign fall = ~pwmSyncP1 & pwmPrevP2;

  for (genvar n = 0; n < pCHANNELS; n++) begin : gCh
    logic [pCOUNT_BITS-1:0] cnt, highCap, perCap;
    logic                   armed, highSeen;

    assign validSet[n]   = rise[n] & armed;
    // Saturation is flagged only on the transition so a cleared TIMEOUT stays clear
    assign timeoutSet[n] = !rise[n] && tick && (cnt == cCntMax - cCntOne);
    assign highArr[n]    = highCap;
    assign perArr[n]     = perCap;

    always_ff @(posedge iCLOCK or negedge iRESET) begin
      if (!iRESET) begin
        cnt      <= '0;
        highCap  <= '0;
        perCap   <= '0;
        armed    <= 1'b0;
        highSeen <= 1'b0;
      end else if (rise[n]) begin
        if (armed) perCap <= cnt;
        cnt      <= tick ? cCntOne : '0;
        armed    <= 1'b1;
        highSeen <= 1'b0;
      end else begin
        if (fall[n] && armed && !highSeen) begin
          highCap  <= cnt;
          highSeen <= 1'b1;
        end
        if (timeoutSet[n]) armed <= 1'b0;
        cnt <= satInc(cnt, tick);
      end
    end
  end

  // Status register: a set in the same cycle as its write-1-to-clear wins
  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      valid   <= '0;
      timeout <= '0;
      oIRQ    <= 1'b0;
    end else begin
      valid   <= (valid   & ~(statW1c ? iWRITE_DATA[pCHANNELS-1:0]    : '0)) | validSet;
      timeout <= (timeout & ~(statW1c ? iWRITE_DATA[16 +: pCHANNELS]  : '0)) | timeoutSet;
      oIRQ    <= |{valid, timeout};
    end
  end

  always_comb begin
    rdNext = '0;
    if (iADDRESS == cAddrPres) begin
      rdNext[pPRESCALER_BITS-1:0] = presMax;
    end else if (iADDRESS == cAddrStat) begin
      rdNext[pCHANNELS-1:0]   = valid;
      rdNext[16 +: pCHANNELS] = timeout;
    end else begin
      for (int n = 0; n < pCHANNELS; n++) begin
        if (iADDRESS == cAddrBits'(2 + 2*n)) rdNext[pCOUNT_BITS-1:0] = highArr[n];
        if (iADDRESS == cAddrBits'(3 + 2*n)) rdNext[pCOUNT_BITS-1:0] = perArr[n];
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET)    oREAD_DATA <= '0;
    else if (iREAD) oREAD_DATA <= rdNext;
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a 32-bit-counter instance for capture/W1C/reset
// behaviour and an 8-bit-counter instance for timeout behaviour.
module tb_pwm_capture;
  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  addr;
  logic        wr, rd;
  logic [31:0] wdata, rdata, rdata8;
  logic [3:0]  pwm, pwm8;
  logic        irq, irq8;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    string       tag;
    logic [3:0]  addr;
    bit          sel8;
    logic [31:0] exp;
  } sbEntry_t;
  sbEntry_t sbQ[$];

  always #5 clk = ~clk;

  pwm_capture #(.pCHANNELS(4), .pPRESCALER_BITS(16), .pCOUNT_BITS(32)) dut (
    .iCLOCK(clk), .iRESET(rstN), .iADDRESS(addr), .iWRITE(wr), .iWRITE_DATA(wdata),
    .iREAD(rd), .oREAD_DATA(rdata), .iPWM(pwm), .oIRQ(irq));

  pwm_capture #(.pCHANNELS(4), .pPRESCALER_BITS(16), .pCOUNT_BITS(8)) dut8 (
    .iCLOCK(clk), .iRESET(rstN), .iADDRESS(addr), .iWRITE(wr), .iWRITE_DATA(wdata),
    .iREAD(rd), .oREAD_DATA(rdata8), .iPWM(pwm8), .oIRQ(irq8));

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] d, output logic [31:0] d8);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d  = rdata;
    d8 = rdata8;
  endtask

  task automatic sbPush(input string tag, input logic [3:0] a, input bit sel8,
                        input logic [31:0] exp);
    sbEntry_t e;
    e.tag = tag; e.addr = a; e.sel8 = sel8; e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic sbDrain();
    sbEntry_t    e;
    logic [31:0] d, d8;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      busRead(e.addr, d, d8);
      checkVal(e.tag, e.sel8 ? d8 : d, e.exp);
    end
  endtask

  task automatic pwmRun(input int ch, input int hi, input int lo, input int n, input bit use8);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < hi; i++) begin
        @(negedge clk);
        if (use8) pwm8[ch] = 1'b1; else pwm[ch] = 1'b1;
      end
      for (int i = 0; i < lo; i++) begin
        @(negedge clk);
        if (use8) pwm8[ch] = 1'b0; else pwm[ch] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int per [4];
    per = '{20, 40, 60, 80};
    rstN = 1'b0; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0; pwm = '0; pwm8 = '0;
    idle(3);
    checkVal("rst_rdata", rdata, 32'h0);
    checkVal("rst_irq", {31'b0, irq}, 32'h0);
    rstN = 1'b1;
    idle(2);
    sbPush("rst_pres", 4'd0, 1'b0, 32'h0);
    sbPush("rst_stat", 4'd1, 1'b0, 32'h0);
    sbPush("rst_high0", 4'd2, 1'b0, 32'h0);
    sbPush("rst_per0", 4'd3, 1'b0, 32'h0);
    sbDrain();

    // First rise only arms; HIGH is captured after it but no period yet
    pwmRun(0, 10, 30, 1, 1'b0);
    idle(5);
    sbPush("arm_stat", 4'd1, 1'b0, 32'h0);
    sbPush("arm_high0", 4'd2, 1'b0, 32'd10);
    sbPush("arm_per0", 4'd3, 1'b0, 32'h0);
    sbDrain();
    checkVal("arm_irq", {31'b0, irq}, 32'h0);

    pwmRun(0, 10, 30, 2, 1'b0);
    idle(5);
    sbPush("p0_high0", 4'd2, 1'b0, 32'd10);
    sbPush("p0_per0", 4'd3, 1'b0, 32'd40);
    sbPush("p0_stat", 4'd1, 1'b0, 32'h1);
    sbDrain();
    checkVal("p0_irq", {31'b0, irq}, 32'h1);

    // W1C clears the bit at once; the interrupt follows one cycle later
    busWrite(4'd1, 32'h1);
    checkVal("w1c_irq_lag", {31'b0, irq}, 32'h1);
    @(negedge clk);
    checkVal("w1c_irq_clr", {31'b0, irq}, 32'h0);
    sbPush("w1c_stat", 4'd1, 1'b0, 32'h0);
    sbDrain();

    // W1C landing in the same cycle as a new capture: the set wins
    @(negedge clk);
    pwm[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr = 4'd1; wdata = 32'h1; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    idle(5);
    pwm[0] = 1'b0;
    idle(5);
    sbPush("w1c_race_stat", 4'd1, 1'b0, 32'h1);
    sbDrain();
    busWrite(4'd1, 32'hFFFF_FFFF);

    // Prescaler 3: one tick every 4 clocks, so 40/160 clocks give 10/40 ticks
    busWrite(4'd0, 32'h0000_0003);
    pwmRun(1, 40, 120, 3, 1'b0);
    idle(5);
    sbPush("ps3_pres", 4'd0, 1'b0, 32'd3);
    sbPush("ps3_high1", 4'd4, 1'b0, 32'd10);
    sbPush("ps3_per1", 4'd5, 1'b0, 32'd40);
    sbPush("ps3_stat", 4'd1, 1'b0, 32'h2);
    sbDrain();
    busWrite(4'd0, 32'h0);
    busWrite(4'd1, 32'hFFFF_FFFF);

    // All four channels at once, 50% duty
    for (int c = 0; c < 480; c++) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) pwm[n] = ((c % per[n]) < (per[n] / 2));
    end
    idle(5);
    for (int n = 0; n < 4; n++) begin
      sbPush($sformatf("ind_high%0d", n), 4'(2 + 2*n), 1'b0, 32'(per[n] / 2));
      sbPush($sformatf("ind_per%0d", n),  4'(3 + 2*n), 1'b0, 32'(per[n]));
    end
    sbPush("ind_stat", 4'd1, 1'b0, 32'hF);
    sbPush("unmapped10", 4'd10, 1'b0, 32'h0);
    sbPush("unmapped15", 4'd15, 1'b0, 32'h0);
    sbDrain();

    // Timeout on the 8-bit instance: saturation at 255 disarms the channel
    busWrite(4'd1, 32'hFFFF_FFFF);
    sbPush("to_pre_stat", 4'd1, 1'b1, 32'h0);
    sbDrain();
    pwmRun(0, 300, 30, 1, 1'b1);
    sbPush("to_stat", 4'd1, 1'b1, 32'h0001_0000);
    sbDrain();
    pwmRun(0, 10, 30, 1, 1'b1);
    sbPush("to_rearm_stat", 4'd1, 1'b1, 32'h0001_0000);
    sbPush("to_rearm_per0", 4'd3, 1'b1, 32'h0);
    sbDrain();
    pwmRun(0, 10, 30, 2, 1'b1);
    idle(5);
    sbPush("to_cap_stat", 4'd1, 1'b1, 32'h0001_0001);
    sbPush("to_cap_high0", 4'd2, 1'b1, 32'd10);
    sbPush("to_cap_per0", 4'd3, 1'b1, 32'd40);
    sbDrain();

    // Asynchronous reset in the middle of a high phase
    busWrite(4'd1, 32'hFFFF_FFFF);
    pwmRun(0, 10, 30, 2, 1'b0);
    busWrite(4'd0, 32'hABCD_0005);
    idle(3);
    sbPush("pre_rst_pres", 4'd0, 1'b0, 32'd5);
    sbPush("pre_rst_stat", 4'd1, 1'b0, 32'h1);
    sbDrain();
    @(negedge clk);
    pwm[0] = 1'b1;
    idle(5);
    #3;
    rstN = 1'b0;
    #1;
    checkVal("async_rst_rdata", rdata, 32'h0);
    checkVal("async_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    idle(10);
    pwm[0] = 1'b0;
    idle(30);
    sbPush("post_rst_pres", 4'd0, 1'b0, 32'h0);
    sbPush("post_rst_stat", 4'd1, 1'b0, 32'h0);
    sbPush("post_rst_per0", 4'd3, 1'b0, 32'h0);
    sbDrain();
    pwmRun(0, 10, 30, 2, 1'b0);
    idle(5);
    sbPush("post_rst_cap_stat", 4'd1, 1'b0, 32'h1);
    sbPush("post_rst_cap_high0", 4'd2, 1'b0, 32'd10);
    sbPush("post_rst_cap_per0", 4'd3, 1'b0, 32'd40);
    sbDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Multi-channel PWM input capture: measures high time and period of each external PWM input in prescaled timebase ticks and exposes the results through the same register-mapped bus style as the PWM generator. It is the receive-side counterpart of the PWM output block, used for servo/RC signal decoding and loopback verification of generated PWM. It sits on the internal register bus next to the other Vidor peripheral IPs and raises a level interrupt when new captures complete.

## Interface
- pCHANNELS, 4, number of capture inputs (1..16)
- pPRESCALER_BITS, 16, width of prescaler counter/max register
- pCOUNT_BITS, 32, width of per-channel tick counter and capture registers (≤32)

- iCLOCK  input  1  system clock; all logic on rising edge
- iRESET  input  1  reset, asynchronous, active-low
- iADDRESS  input  $clog2(2*pCHANNELS+2)  register address
- iWRITE  input  1  write strobe, single cycle
- iWRITE_DATA  input  32  write data
- iREAD  input  1  read strobe, single cycle
- oREAD_DATA  output  32  read data, valid cycle after iREAD
- iPWM  input  pCHANNELS  asynchronous PWM inputs
- oIRQ  output  1  registered OR of all status bits

## Operation
- Register map: 0 prescaler max (RW, low pPRESCALER_BITS used); 1 status (R, write-1-to-clear); 2+2n high time of channel n (RO); 3+2n period of channel n (RO). Unmapped reads return 0; writes to RO/unmapped addresses ignored.
- Status: bit n (n<pCHANNELS) = VALID[n], new period captured; bit 16+n = TIMEOUT[n]; other bits read 0.
- Prescaler: counter increments every clock; when counter ≥ max, counter←0 and TICK pulses high the next cycle for one cycle. Max P ⇒ one tick per P+1 clocks; P=0 ⇒ TICK high every cycle after the first post-reset cycle.
- Input path per channel: 2-flop synchronizer, then previous-value flop; RISE/FALL are single-cycle pulses from the synchronized value.
- Per-channel counter CNT, flags ARMED and HIGH_SEEN:
  - RISE: if ARMED, PERIOD←CNT, VALID set; CNT←TICK?1:0; ARMED←1; HIGH_SEEN←0.
  - FALL: if ARMED and not HIGH_SEEN, HIGH←CNT, HIGH_SEEN←1; else ignored.
  - Otherwise: CNT←CNT+TICK, saturating at all-ones.
  - CNT reaching all-ones: TIMEOUT set, ARMED←0, CNT holds; next RISE re-arms without capture.
- Captured values are latched from CNT before its update in the edge cycle, i.e. value = number of TICK pulses from edge-detect cycle (inclusive) to next edge-detect cycle (exclusive).
- HIGH and PERIOD persist until overwritten; reading does not clear VALID.
- oIRQ ← |status bits, registered.

## Timing
- Reset (iRESET=0, async): all counters, captures, flags, prescaler max, oREAD_DATA, oIRQ = 0; synchronizers = 0.
- iPWM edge → RISE/FALL pulse: 3 clocks (2 sync + 1 detect).
- Capture → status bit visible on read: VALID/TIMEOUT set at end of edge cycle; oIRQ one cycle later.
- Read: oREAD_DATA registered from iADDRESS at the iREAD cycle; holds value until next iREAD.
- Simultaneous W1C and set of the same status bit: set wins.
- Simultaneous iREAD of a capture register and its update: returns the pre-update value.
- Prescaler write mid-count: new max takes effect on next compare (≥ compare ⇒ lowering below current count forces immediate wrap).
- Input pulses shorter than 2 clocks may be missed; no error flagged.
- Reset deasserted mid-PWM: first RISE only arms; first VALID after second RISE.

## Test plan
- Prescaler 0, iPWM high 10 / low 30 clocks, repeated: after second rise, channel 0 HIGH=10, PERIOD=40, status bit0=1, oIRQ=1 one cycle later.
- Prescaler 3, same waveform scaled to high 40 / period 160 clocks: HIGH=10, PERIOD=40 (±1 tick depending on phase; check exact value against tick count model).
- W1C: write 0x1 to status → bit0 clears, oIRQ falls next cycle; write coincident with new capture → bit0 stays 1.
- Timeout: pCOUNT_BITS=8, prescaler 0, hold iPWM high 300 clocks → TIMEOUT bit16 set at CNT=255, ARMED cleared; next rise gives no VALID, following rise gives valid capture.
- Channel independence: 4 channels with periods 20/40/60/80 clocks, duty 50% → each PERIOD/HIGH correct, VALID bits set independently; unmapped address read returns 0.
- Async reset asserted mid-capture → all outputs 0 immediately; after release, first rise gives no capture.
